// File: rtl/inspeccion_pkg.sv
// Shared constants and types for the inspection verdict consumer and reject diverter.
package inspeccion_pkg;

    localparam int unsigned E_W    = 2;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned TMR_W  = 16;

    localparam logic [E_W-1:0] E_IDLE = 2'b00;
    localparam logic [E_W-1:0] E_INSP = 2'b01;
    localparam logic [E_W-1:0] E_ACC  = 2'b10;
    localparam logic [E_W-1:0] E_REJ  = 2'b11;

    localparam logic [SEL_W-1:0] SEL_ACC    = 2'b00;
    localparam logic [SEL_W-1:0] SEL_REJ    = 2'b01;
    localparam logic [SEL_W-1:0] SEL_STATUS = 2'b10;
    localparam logic [SEL_W-1:0] SEL_CONSEC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DELAY = 2'b01,
        ST_FIRE  = 2'b10
    } desvio_state_e;

    typedef struct packed {
        logic       alarm;
        logic       overflow;
        logic       pending;
        logic [1:0] state;
        logic [2:0] rsvd;
    } status_t;

    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/desvio_seq.sv
// Reject diverter sequencer: travel delay, actuator pulse, one-deep pending queue.
module desvio_seq
    import inspeccion_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES = 1000,
    parameter int unsigned PULSE_CYCLES = 200
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    output logic          divert,
    output logic          pending,
    output logic          overflow_set,
    output desvio_state_e state
);

    localparam logic [TMR_W-1:0] DLY_LOAD = TMR_W'(DELAY_CYCLES - 1);
    localparam logic [TMR_W-1:0] PLS_LOAD = TMR_W'(PULSE_CYCLES - 1);

    desvio_state_e    state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             pending_q, pending_d;
    logic             divert_q, divert_d;
    logic             ovf_set_q, ovf_set_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            pending_q <= 1'b0;
            divert_q  <= 1'b0;
            ovf_set_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            divert_q  <= divert_d;
            ovf_set_q <= ovf_set_d;
        end
    end

    // Pending is resolved before the FIRE exit so a last-cycle request chains directly.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        ovf_set_d = 1'b0;

        if (req && (state_q != ST_IDLE)) begin
            if (pending_q) ovf_set_d = 1'b1;
            else           pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_DELAY;
                    timer_d = DLY_LOAD;
                end
            end
            ST_DELAY: begin
                if (timer_q == '0) begin
                    state_d = ST_FIRE;
                    timer_d = PLS_LOAD;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_FIRE: begin
                if (timer_q == '0) begin
                    if (pending_d) begin
                        state_d   = ST_DELAY;
                        timer_d   = DLY_LOAD;
                        pending_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        divert_d = (state_d == ST_FIRE);
    end

    assign divert       = divert_q;
    assign pending      = pending_q;
    assign overflow_set = ovf_set_q;
    assign state        = state_q;

endmodule

// File: rtl/inspeccion_desvio.sv
// Verdict event tallies, reject diverter control and 8-bit readout.
// Optional consecutive-reject alarm built when INSPECCION_ALARM_EN is defined.
module inspeccion_desvio
    import inspeccion_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES = 1000,
    parameter int unsigned PULSE_CYCLES = 200,
    parameter int unsigned ALARM_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [E_W-1:0]   e_code,
    input  logic             clr,
    input  logic [SEL_W-1:0] sel,
    output logic [7:0]       data_out,
    output logic             divert,
    output logic             alarm
);

    logic [E_W-1:0]   e_prev_q, e_prev_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] rej_q, rej_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       data_out_q, data_out_d;

    logic             ev_c, acc_ev_c, rej_ev_c;
    logic             seq_pending, seq_ovf_set;
    desvio_state_e    seq_state;
    logic [CNT_W-1:0] consec_v;
    logic             alarm_v;
    status_t          status_c;

    // A verdict counts once when it first appears; accept->reject is a new event.
    assign ev_c     = ena && e_code[1] && (e_code != e_prev_q);
    assign acc_ev_c = ev_c && (e_code == E_ACC);
    assign rej_ev_c = ev_c && (e_code == E_REJ);

    desvio_seq #(
        .DELAY_CYCLES (DELAY_CYCLES),
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (rej_ev_c),
        .divert       (divert),
        .pending      (seq_pending),
        .overflow_set (seq_ovf_set),
        .state        (seq_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_prev_q   <= E_IDLE;
            acc_q      <= '0;
            rej_q      <= '0;
            ovf_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            e_prev_q   <= e_prev_d;
            acc_q      <= acc_d;
            rej_q      <= rej_d;
            ovf_q      <= ovf_d;
            data_out_q <= data_out_d;
        end
    end

    always_comb begin
        e_prev_d = e_code;
        acc_d    = acc_q;
        rej_d    = rej_q;
        ovf_d    = ovf_q;
        if (clr) begin
            acc_d = '0;
            rej_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (acc_ev_c)    acc_d = sat_inc(acc_q);
            if (rej_ev_c)    rej_d = sat_inc(rej_q);
            if (seq_ovf_set) ovf_d = 1'b1;
        end
    end

`ifdef INSPECCION_ALARM_EN
    logic [CNT_W-1:0] consec_q, consec_d;
    logic             alarm_q, alarm_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            consec_q <= '0;
            alarm_q  <= 1'b0;
        end else begin
            consec_q <= consec_d;
            alarm_q  <= alarm_d;
        end
    end

    always_comb begin
        consec_d = consec_q;
        alarm_d  = alarm_q;
        if (clr) begin
            consec_d = '0;
            alarm_d  = 1'b0;
        end else begin
            if (acc_ev_c)      consec_d = '0;
            else if (rej_ev_c) consec_d = sat_inc(consec_q);
            if (consec_d >= CNT_W'(ALARM_THRESH)) alarm_d = 1'b1;
        end
    end

    assign consec_v = consec_q;
    assign alarm_v  = alarm_q;
`else
    logic unused_alarm_thresh;
    assign unused_alarm_thresh = ^CNT_W'(ALARM_THRESH);
    assign consec_v = '0;
    assign alarm_v  = 1'b0;
`endif

    always_comb begin
        status_c.alarm    = alarm_v;
        status_c.overflow = ovf_q;
        status_c.pending  = seq_pending;
        status_c.state    = 2'(seq_state);
        status_c.rsvd     = 3'b000;
    end

    always_comb begin
        data_out_d = '0;
        case (sel)
            SEL_ACC:    data_out_d = acc_q;
            SEL_REJ:    data_out_d = rej_q;
            SEL_STATUS: data_out_d = status_c;
            SEL_CONSEC: data_out_d = consec_v;
            default:    data_out_d = '0;
        endcase
    end

    assign data_out = data_out_q;
    assign alarm    = alarm_v;

endmodule

// File: tb/tb_inspeccion_desvio.sv
// Directed bench for inspeccion_desvio; diverter rises are scoreboarded against expected cycles.
module tb_inspeccion_desvio;
    import inspeccion_pkg::*;

    localparam int D = 20;
    localparam int P = 5;
    localparam int T = 3;
`ifdef INSPECCION_ALARM_EN
    localparam bit AL = 1'b1;
`else
    localparam bit AL = 1'b0;
`endif
    localparam logic [7:0] AL_BIT = AL ? 8'h80 : 8'h00;

    logic       clk = 1'b0;
    logic       rst_n, ena, clr;
    logic [1:0] e_code, sel;
    logic [7:0] data_out;
    logic       divert, alarm;

    inspeccion_desvio #(
        .DELAY_CYCLES (D),
        .PULSE_CYCLES (P),
        .ALARM_THRESH (T)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .e_code   (e_code),
        .clr      (clr),
        .sel      (sel),
        .data_out (data_out),
        .divert   (divert),
        .alarm    (alarm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_q[$];
    int rise_cyc = 0;
    int n_rise   = 0;
    bit abort_pulse = 1'b0;
    logic div_prev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pops the expected rise cycle on every divert rising edge; checks width on fall.
    always @(negedge clk) begin
        if (divert === 1'b1 && div_prev === 1'b0) begin
            n_rise++;
            rise_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_rise observed_cycle=%0d expected=none", cyc);
            end else begin
                chk("rise_cycle", cyc, exp_q.pop_front());
            end
        end
        if (divert === 1'b0 && div_prev === 1'b1 && !abort_pulse)
            chk("pulse_width", cyc - rise_cyc, P);
        div_prev = divert;
    end

    task automatic step(input logic [1:0] e);
        e_code = e;
        @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] s, input string tag, input logic [7:0] exp);
        sel = s;
        @(negedge clk);
        chk(tag, data_out, exp);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c0;
        int n0;
        rst_n = 1'b0; ena = 1'b1; clr = 1'b0; e_code = E_IDLE; sel = SEL_ACC;
        wait_n(2);
        chk("reset_data_out", data_out, 0);
        chk("reset_divert", divert, 0);
        chk("reset_alarm", alarm, 0);
        rst_n = 1'b1;
        @(negedge clk);
        rd(SEL_STATUS, "reset_status", 8'h00);

        // held accept counts once, then a single reject pulse
        repeat (5) step(E_ACC);
        step(E_IDLE);
        exp_q.push_back(cyc + 1 + D);
        step(E_REJ);
        step(E_IDLE);
        rd(SEL_ACC, "t1_acc", 8'd1);
        rd(SEL_REJ, "t1_rej", 8'd1);
        wait_n(D + P + 5);
        chk("t1_drained", exp_q.size(), 0);

        // three rejects inside one sequence: one pending, one overflow
        do_clr();
        c0 = cyc;
        exp_q.push_back(c0 + 1 + D);
        exp_q.push_back(c0 + 1 + D + P + D);
        step(E_REJ); step(E_IDLE);
        step(E_REJ); step(E_IDLE);
        step(E_REJ); step(E_IDLE);
        rd(SEL_STATUS, "t2_status_busy", AL_BIT | 8'h68);
        rd(SEL_REJ, "t2_rej", 8'd3);
        wait_n(2 * D + 2 * P + 10);
        rd(SEL_STATUS, "t2_status_idle", AL_BIT | 8'h40);
        chk("t2_drained", exp_q.size(), 0);

        // accept counter saturation
        do_clr();
        repeat (300) begin
            step(E_ACC);
            step(E_IDLE);
        end
        rd(SEL_ACC, "t3_acc_sat", 8'd255);
        rd(SEL_REJ, "t3_rej", 8'd0);

        // consecutive-reject alarm: R R A R R R
        do_clr();
        c0 = cyc;
        exp_q.push_back(c0 + 1 + D);
        exp_q.push_back(c0 + 1 + D + P + D);
        step(E_REJ); step(E_IDLE);
        step(E_REJ); step(E_IDLE);
        step(E_ACC); step(E_IDLE);
        step(E_REJ); step(E_IDLE);
        step(E_REJ);
        chk("t4_alarm_before", alarm, 0);
        step(E_IDLE);
        step(E_REJ);
        chk("t4_alarm_rise", alarm, AL);
        step(E_IDLE);
        wait_n(3);
        chk("t4_alarm_sticky", alarm, AL);
        rd(SEL_CONSEC, "t4_consec", AL ? 8'd3 : 8'd0);
        rd(SEL_REJ, "t4_rej", 8'd5);
        do_clr();
        chk("t4_alarm_clr", alarm, 0);
        rd(SEL_CONSEC, "t4_consec_clr", 8'd0);
        wait_n(2 * D + 2 * P + 10);
        chk("t4_drained", exp_q.size(), 0);

        // disabled input ignores a reject
        do_clr();
        n0 = n_rise;
        ena = 1'b0;
        step(E_REJ);
        step(E_IDLE);
        ena = 1'b1;
        step(E_IDLE);
        rd(SEL_REJ, "t5_rej", 8'd0);
        wait_n(D + P + 5);
        chk("t5_no_pulse", n_rise, n0);

        // reset during FIRE drops divert at once and loses the pending request
        exp_q.push_back(cyc + 1 + D);
        step(E_REJ); step(E_IDLE);
        step(E_REJ); step(E_IDLE);
        for (int i = 0; i < D + 5; i++) begin
            if (divert === 1'b1) break;
            @(negedge clk);
        end
        chk("t6_divert_up", divert, 1);
        wait_n(2);
        abort_pulse = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk("t6_async_drop", divert, 0);
        @(negedge clk);
        chk("t6_reset_data", data_out, 0);
        rst_n = 1'b1;
        @(negedge clk);
        abort_pulse = 1'b0;
        n0 = n_rise;
        rd(SEL_STATUS, "t6_status_idle", 8'h00);
        wait_n(2 * D + P + 5);
        chk("t6_pending_lost", n_rise, n0);

        // clear and reject together: count cleared, pulse still issued
        clr = 1'b1;
        exp_q.push_back(cyc + 1 + D);
        step(E_REJ);
        clr = 1'b0;
        step(E_IDLE);
        rd(SEL_REJ, "t7_rej", 8'd0);
        rd(SEL_STATUS, "t7_status_delay", 8'h08);
        wait_n(D + P + 5);
        chk("t7_drained", exp_q.size(), 0);

        chk("final_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inspeccion_desvio.md
# inspeccion_desvio

Downstream consumer of the inspection Moore FSM verdict code E[1:0]. Detects accept/reject verdict events, keeps saturating accept/reject tallies, and sequences a timed reject-diverter pulse (travel delay, then actuator pulse) with one-deep queuing of back-to-back rejects. Counters and status are read out over a selectable 8-bit bus for the chip's output pins.

## Interface
Parameters:
- DELAY_CYCLES, 1000: clock cycles from reject event to diverter assertion (belt travel); range 1..65535.
- PULSE_CYCLES, 200: diverter high time in cycles; range 1..65535.
- ALARM_THRESH, 3: consecutive rejects that raise the alarm; range 1..255.

Ports:
- clk  in  1  system clock (1 MHz).
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  enable. Low: new verdict events are ignored; the in-flight diverter sequence still completes.
- e_code  in  2  verdict code from the inspection FSM. Encoding: 00 idle, 01 inspecting, 10 accept, 11 reject.
- clr  in  1  synchronous clear of counters, alarm and overflow.
- sel  in  2  readout select: 00 accept count, 01 reject count, 10 status, 11 consecutive-reject count.
- data_out  out  8  registered readout.
- divert  out  1  registered diverter actuator drive.
- alarm  out  1  sticky consecutive-reject alarm.

## Operation
- e_prev register, reset 00. Event when ena=1, e_code ∈ {10,11}, and e_code != e_prev. A held verdict counts once; 10→11 counts as a new reject.
- Accept event: acc_cnt+1, saturating at 255; consec cleared to 0.
- Reject event: rej_cnt+1, saturating at 255; consec+1, saturating at 255; diverter request.
- Diverter FSM states:
  - IDLE: on request, load timer=DELAY_CYCLES-1 and go to DELAY.
  - DELAY: timer counts down; at 0, load PULSE_CYCLES-1 and go to FIRE.
  - FIRE: divert=1; timer counts down; at 0, go to DELAY if pending, otherwise IDLE. Taking pending clears it.
- Request while not IDLE: set pending. Request while pending already set: set sticky overflow; the extra reject is counted but not diverted.
- Request in the final FIRE cycle with pending clear: pending is set, then consumed at the same edge as the FIRE→DELAY transition.
- clr: zeroes acc_cnt, rej_cnt, consec, alarm and overflow. It does not touch the FSM, pending or divert. With clr and an event in the same cycle, clr wins for counters and consec. The reject still issues its diverter request for physical safety.
- Status byte: {alarm, overflow, pending, state[1:0], 3'b000}. State encoding: IDLE 00, DELAY 01, FIRE 10.
- Reset values: all counters 0, FSM IDLE, pending 0, overflow 0, divert 0, alarm 0, data_out 00.

## Timing
- Event at edge k (e_code stable before k): counters hold new values after k; data_out reflects them after k+1.
- divert rises at edge k+DELAY_CYCLES and stays high exactly PULSE_CYCLES cycles.
- With pending set, the second pulse rises DELAY_CYCLES cycles after the first falls.
- Reset asserted mid-sequence: divert drops asynchronously; the pending request is lost.

## Configuration
- INSPECCION_ALARM_EN defined: consec counter and alarm logic are present. alarm sets (sticky) at the edge where consec reaches ALARM_THRESH; only clr or reset clears it. sel=11 returns consec.
- INSPECCION_ALARM_EN undefined: no consec logic; alarm tied 0; status bit 7 reads 0; sel=11 returns 00.

## Structure
- Package inspeccion_pkg holds:
  - E code constants (E_IDLE, E_INSP, E_ACC, E_REJ).
  - Diverter state enum.
  - sel encodings.
- Sub-module desvio_seq: the diverter FSM plus the 16-bit timer and pending/overflow. Interface: req in; divert, pending, overflow_set and state out.

## Test plan
- e_code 00→10 held for 5 cycles, then 00→11 → acc=1, rej=1; divert high after DELAY_CYCLES for PULSE_CYCLES.
- Three rejects each separated by a 00 gap, within one sequence (DELAY=20, PULSE=5) → two pulses spaced 20 cycles after the first falls; overflow=1, status bit 6 set, rej=3.
- 300 accept events → sel=00 reads 255 (saturated).
- With macro, ALARM_THRESH=3: reject, reject, accept, reject, reject, reject → alarm rises at the 5th reject, stays high; clr → alarm=0, sel=11 reads 0.
- ena=0 during a reject verdict → no count, no divert. Reset asserted in FIRE → divert=0 immediately, state IDLE.
- clr with a reject in the same cycle → rej=0 afterwards, but divert pulse still occurs.
